// File: rtl/piano_pkg.sv
// Shared note table and helpers for the piano tone bank.
// Note frequencies are kept in hundredths of a Hz so half-periods stay integer-exact.
package piano_pkg;

  localparam int MAX_KEYS = 64;

  localparam longint NOTE_HZ [8] = '{26163, 29366, 32963, 34923, 39200, 44000, 49388, 52325};

  // round(clk_hz / (2 * f)) with f in centi-Hz
  function automatic longint half_period(input longint clk_hz, input int idx);
    return (clk_hz * 100 + NOTE_HZ[idx]) / (2 * NOTE_HZ[idx]);
  endfunction

  function automatic int unsigned popcount(input logic [MAX_KEYS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_KEYS; i++) n = n + 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/tone_channel.sv
// One piano key: two-flop synchroniser, debouncer and octave-shifted square-wave divider.
module tone_channel
  import piano_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DIV_W           = 18,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NOTE_IDX        = 0,
  parameter int OCT_OFFSET      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  input  logic [1:0] octave,
  output logic       key_deb,
  output logic       tone
);

  localparam logic [DIV_W-1:0] HP     = DIV_W'(half_period(longint'(CLK_HZ), NOTE_IDX));
  localparam int               DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LIM = DB_W'(DEBOUNCE_CYCLES);

  function automatic logic [DIV_W-1:0] calc_limit(input logic [1:0] oct);
    int               sh;
    logic [DIV_W-1:0] lim;
    sh = int'(oct) + OCT_OFFSET;
    if (sh > DIV_W - 1) sh = DIV_W - 1;
    lim = HP >> sh;
    if (lim == '0) lim = DIV_W'(1);
    return lim;
  endfunction

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q, deb_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] lim_q, lim_d;
  logic             tone_q, tone_d;

  always_comb begin
    sync1_d  = key;
    sync2_d  = sync1_q;
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (db_cnt_q + DB_W'(1) == DB_LIM) deb_d = ~deb_q;
      else db_cnt_d = db_cnt_q + DB_W'(1);
    end

    // limit tracks the octave while idle, then is only resampled at reloads
    div_cnt_d = div_cnt_q + DIV_W'(1);
    tone_d    = tone_q;
    lim_d     = lim_q;
    if (!deb_q) begin
      div_cnt_d = '0;
      tone_d    = 1'b0;
      lim_d     = calc_limit(octave);
    end else if (div_cnt_q == lim_q - DIV_W'(1)) begin
      div_cnt_d = '0;
      tone_d    = ~tone_q;
      lim_d     = calc_limit(octave);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      db_cnt_q  <= '0;
      div_cnt_q <= '0;
      lim_q     <= calc_limit(2'b00);
      tone_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      db_cnt_q  <= db_cnt_d;
      div_cnt_q <= div_cnt_d;
      lim_q     <= lim_d;
      tone_q    <= tone_d;
    end
  end

  assign key_deb = deb_q;
  assign tone    = tone_q;

endmodule

// File: rtl/piano_tone_bank.sv
// Polyphonic square-wave tone bank: per-key tone channels, debounced key count
// and a first-order PDM mix of all active tones onto one pin.
module piano_tone_bank
  import piano_pkg::*;
#(
  parameter int NUM_KEYS        = 8,
  parameter int CLK_HZ          = 50_000_000,
  parameter int DIV_W           = 18,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_KEYS-1:0]             keys,
  input  logic [1:0]                      octave,
  output logic [NUM_KEYS-1:0]             tone_out,
  output logic [$clog2(NUM_KEYS+1)-1:0]   key_count,
  output logic                            mix_out
);

  localparam int KC_W  = $clog2(NUM_KEYS + 1);
  localparam int ACC_W = $clog2(NUM_KEYS) + 1;

  logic [NUM_KEYS-1:0] deb_w, tone_w;
  logic [MAX_KEYS-1:0] deb_ext, tone_ext;
  logic [KC_W-1:0]     key_count_q, key_count_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W:0]      sum;
  logic                mix_q, mix_d;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
    tone_channel #(
      .CLK_HZ          (CLK_HZ),
      .DIV_W           (DIV_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .NOTE_IDX        (gi % 8),
      .OCT_OFFSET      (gi / 8)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .key     (keys[gi]),
      .octave  (octave),
      .key_deb (deb_w[gi]),
      .tone    (tone_w[gi])
    );
  end

  always_comb begin
    deb_ext                 = '0;
    tone_ext                = '0;
    deb_ext[NUM_KEYS-1:0]   = deb_w;
    tone_ext[NUM_KEYS-1:0]  = tone_w;
    key_count_d             = KC_W'(popcount(deb_ext));

    // emit a 1 each time the running sum of active tones crosses NUM_KEYS
    sum = {1'b0, acc_q} + (ACC_W+1)'(popcount(tone_ext));
    if (sum >= (ACC_W+1)'(NUM_KEYS)) begin
      mix_d = 1'b1;
      acc_d = ACC_W'(sum - (ACC_W+1)'(NUM_KEYS));
    end else begin
      mix_d = 1'b0;
      acc_d = sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_count_q <= '0;
      acc_q       <= '0;
      mix_q       <= 1'b0;
    end else begin
      key_count_q <= key_count_d;
      acc_q       <= acc_d;
      mix_q       <= mix_d;
    end
  end

  assign tone_out  = tone_w;
  assign key_count = key_count_q;
  assign mix_out   = mix_q;

endmodule

// File: tb/tb_piano_tone_bank.sv
// Directed and randomized checks of the piano tone bank against a note-table reference model.
module tb_piano_tone_bank;

  localparam int CLK16 = 100_000;
  localparam int CLK8  = 20_000;
  localparam int DEB   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys16 = '0;
  logic [1:0]  oct16 = '0;
  logic [15:0] tone16;
  logic [4:0]  kc16;
  logic        mix16;
  logic [7:0]  keys8 = '0;
  logic [1:0]  oct8 = '0;
  logic [7:0]  tone8;
  logic [3:0]  kc8;
  logic        mix8;

  int vec = 0;
  int err = 0;

  real note_hz [8] = '{261.63, 293.66, 329.63, 349.23, 392.00, 440.00, 493.88, 523.25};

  always #5 clk = ~clk;

  piano_tone_bank #(.NUM_KEYS(16), .CLK_HZ(CLK16), .DIV_W(18), .DEBOUNCE_CYCLES(DEB)) dut16 (
    .clk(clk), .rst(rst), .keys(keys16), .octave(oct16),
    .tone_out(tone16), .key_count(kc16), .mix_out(mix16));

  piano_tone_bank #(.NUM_KEYS(8), .CLK_HZ(CLK8), .DIV_W(18), .DEBOUNCE_CYCLES(DEB)) dut8 (
    .clk(clk), .rst(rst), .keys(keys8), .octave(oct8),
    .tone_out(tone8), .key_count(kc8), .mix_out(mix8));

  function automatic int exp_limit(input int clk_hz, input int key, input int oct);
    int hp, sh, lim;
    hp = $rtoi(clk_hz / (2.0 * note_hz[key % 8]) + 0.5);
    sh = oct + key / 8;
    if (sh > 17) sh = 17;
    lim = hp >> sh;
    if (lim < 1) lim = 1;
    return lim;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vec++;
    assert (obs === expv) else begin
      err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic wait_tone16(input int k, input logic v, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (tone16[k] === v) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_kc16(input int v, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (kc16 === 5'(v)) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t, k, o, lim, l5, l5o1, l13, s, acc_m, ones, sum_pop, diff;
    logic v, pending;
    logic [0:18] pat;

    // reset held with keys toggling
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("rst_tone16", 64'(tone16), 0);
      check("rst_kc16", 64'(kc16), 0);
      check("rst_mix16", 64'(mix16), 0);
      check("rst_tone8", 64'(tone8), 0);
      check("rst_kc8", 64'(kc8), 0);
      check("rst_mix8", 64'(mix8), 0);
      keys16 = 16'($urandom);
      keys8  = (c % 2 == 1) ? 8'hFF : 8'h00;
    end
    @(negedge clk);
    rst = 1'b0;
    keys16 = '0;
    keys8 = '0;
    repeat (10) @(negedge clk);
    check("idle_kc16", 64'(kc16), 0);
    check("idle_tone16", 64'(tone16), 0);

    // key 5 press: debounce latency, first toggle, period
    l5   = exp_limit(CLK16, 5, 0);
    l5o1 = exp_limit(CLK16, 5, 1);
    keys16[5] = 1'b1;
    wait_kc16(1, 50, n);
    check("press_kc_latency", 64'(n), 64'(2 + DEB + 1));
    t = n;
    wait_tone16(5, 1'b1, 1000, n);
    check("press_first_toggle", 64'(t + n), 64'(2 + DEB + l5));
    wait_tone16(5, 1'b0, 1000, n);
    check("half_period_lo", 64'(n), 64'(l5));
    wait_tone16(5, 1'b1, 1000, n);
    check("half_period_hi", 64'(n), 64'(l5));

    // asynchronous reset while tone is high
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tone16", 64'(tone16), 0);
    check("async_rst_kc16", 64'(kc16), 0);
    check("async_rst_mix16", 64'(mix16), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_tone16(5, 1'b1, 1000, n);
    check("post_rst_first_toggle", 64'(n), 64'(2 + DEB + l5));

    // short glitches on key 0 are rejected
    pat = 19'b111_000_111_0000000000;
    for (int j = 0; j < 19; j++) begin
      @(negedge clk);
      check("glitch_tone0", 64'(tone16[0]), 0);
      check("glitch_kc16", 64'(kc16), 1);
      keys16[0] = pat[j];
    end

    // a 5-cycle press on key 0 is accepted and released
    @(negedge clk);
    keys16[0] = 1'b1;
    repeat (5) @(negedge clk);
    keys16[0] = 1'b0;
    wait_kc16(2, 20, n);
    check("short_press_rise", 64'(5 + n), 64'(2 + DEB + 1));
    t = 5 + n;
    wait_kc16(1, 20, n);
    check("short_press_fall", 64'(t + n), 64'(5 + 2 + DEB + 1));
    check("short_press_tone0", 64'(tone16[0]), 0);

    // octave change mid half-period
    v = tone16[5];
    wait_tone16(5, ~v, 1000, n);
    v = tone16[5];
    repeat (40) @(negedge clk);
    oct16 = 2'd1;
    wait_tone16(5, ~v, 1000, n);
    check("octave_current_half", 64'(40 + n), 64'(l5));
    v = tone16[5];
    wait_tone16(5, ~v, 1000, n);
    check("octave_next_half_a", 64'(n), 64'(l5o1));
    v = tone16[5];
    wait_tone16(5, ~v, 1000, n);
    check("octave_next_half_b", 64'(n), 64'(l5o1));
    oct16 = 2'd0;

    // release key 5, then key 13 (upper bank, one octave up)
    keys16[5] = 1'b0;
    wait_kc16(0, 20, n);
    check("release5_kc", 64'(n), 64'(2 + DEB + 1));
    check("release5_tone", 64'(tone16), 0);
    l13 = exp_limit(CLK16, 13, 0);
    keys16[13] = 1'b1;
    wait_tone16(13, 1'b1, 1000, n);
    check("key13_first_toggle", 64'(n), 64'(2 + DEB + l13));
    check("key13_kc", 64'(kc16), 1);
    wait_tone16(13, 1'b0, 1000, n);
    check("key13_half_lo", 64'(n), 64'(l13));
    wait_tone16(13, 1'b1, 1000, n);
    check("key13_half_hi", 64'(n), 64'(l13));
    keys16[13] = 1'b0;
    repeat (2 + DEB) @(negedge clk);
    check("key13_tone_before_force", 64'(tone16[13]), 1);
    check("key13_kc_before_update", 64'(kc16), 1);
    @(negedge clk);
    check("key13_tone_forced", 64'(tone16[13]), 0);
    check("key13_kc_zero", 64'(kc16), 0);

    // random key / octave trials
    for (int tr = 0; tr < 6; tr++) begin
      k = $urandom_range(15, 0);
      o = $urandom_range(3, 0);
      lim = exp_limit(CLK16, k, o);
      oct16 = 2'(o);
      @(negedge clk);
      keys16[k] = 1'b1;
      wait_tone16(k, 1'b1, 1000, n);
      check("rand_first_toggle", 64'(n), 64'(2 + DEB + lim));
      wait_tone16(k, 1'b0, 1000, n);
      check("rand_half_period", 64'(n), 64'(lim));
      keys16[k] = 1'b0;
      wait_kc16(0, 20, n);
      check("rand_release_kc", 64'(n), 64'(2 + DEB + 1));
      repeat (2) @(negedge clk);
      check("rand_release_tone", 64'(tone16), 0);
    end

    // PDM mixer on the 8-key bank: all keys on, then random patterns
    pending = 1'b0;
    acc_m = 0;
    ones = 0;
    sum_pop = 0;
    keys8 = 8'hFF;
    oct8 = 2'($urandom);
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      check("mix_out", 64'(mix8), 64'(pending));
      ones = ones + int'(mix8);
      sum_pop = sum_pop + $countones(tone8);
      s = acc_m + $countones(tone8);
      if (s >= 8) begin
        pending = 1'b1;
        acc_m = s - 8;
      end else begin
        pending = 1'b0;
        acc_m = s;
      end
      if (c == 10) check("kc8_all_on", 64'(kc8), 8);
      if (c >= 250 && c % 60 == 10) begin
        keys8 = 8'($urandom);
        oct8 = 2'($urandom);
      end
    end
    diff = 8 * ones - sum_pop;
    check("mix_density", 64'(diff > -16 && diff < 16), 1);
    keys8 = '0;
    repeat (12) @(negedge clk);
    check("mix_idle_tone8", 64'(tone8), 0);
    check("mix_idle_kc8", 64'(kc8), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/piano_tone_bank.md
Name: piano_tone_bank

Overview:
- Parametrised polyphonic square-wave tone generator for the FPGA piano.
- Each of NUM_KEYS key inputs is synchronised and debounced, then gates its own divided-clock tone on a per-key output pin.
- Adds a global octave shift, a debounced key count, and a 1-bit PDM mix output that sums all active tones onto a single speaker pin.
- Sits between board switches/keys and the GPIO banks.

Parameters:
- NUM_KEYS, 8, number of key channels; >=1.
- CLK_HZ, 50_000_000, system clock frequency used to derive half-period constants.
- DIV_W, 18, width of each tone divider counter; must hold HALF_PERIOD of C4.
- DEBOUNCE_CYCLES, 4, cycles a synchronised key must be stable before its debounced level changes; >=1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- keys  in  NUM_KEYS  raw key/switch levels, asynchronous to clk; 1 = pressed.
- octave  in  2  global octave shift 0..3; sampled by each channel at its divider reload.
- tone_out  out  NUM_KEYS  per-key square wave; 0 while the key is released.
- key_count  out  $clog2(NUM_KEYS+1)  popcount of debounced keys.
- mix_out  out  1  PDM of the sum of tone_out bits.

Behaviour:
- Reset (async, active-high):
  - tone_out = 0, mix_out = 0, key_count = 0.
  - All synchronisers, debounce counters, divider counters and the PDM accumulator clear to 0.
  - Reset mid-tone silences the tone immediately, without waiting for a clock edge.
- Synchroniser:
  - 2 flops per key.
- Debounce:
  - A per-key counter increments while the synchronised level differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
  - Press latency from raw edge to debounced edge: 2 + DEBOUNCE_CYCLES cycles.
- Note mapping:
  - Key i plays note i mod 8 from the table C4 D4 E4 F4 G4 A4 B4 C5 (261.63, 293.66, 329.63, 349.23, 392.00, 440.00, 493.88, 523.25 Hz).
  - Key i is shifted up by floor(i/8) octaves.
  - Effective shift = octave + floor(i/8), saturating at DIV_W-1.
  - limit = HALF_PERIOD[i mod 8] >> shift, clamped to a minimum of 1.
- Divider (per channel):
  - While debounced key = 0: counter = 0 and tone_out[i] = 0, forced on the cycle after the debounced fall.
  - While debounced key = 1: counter counts 0..limit-1.
  - On counter == limit-1: toggle tone_out[i], counter returns to 0, and limit is recomputed from the current octave.
  - An octave change therefore takes effect only at the next reload; the current half-period is never truncated.
  - First toggle after press: limit cycles after the debounced rise. Output period = 2*limit cycles.
- key_count: registered popcount of the debounced keys; 1 cycle after the debounce update.
- PDM mixer:
  - acc width $clog2(NUM_KEYS)+1.
  - Each cycle: s = acc + popcount(tone_out).
  - If s >= NUM_KEYS: mix_out = 1 and acc = s - NUM_KEYS; else mix_out = 0 and acc = s.
  - Density of mix_out equals active-high tones / NUM_KEYS.
  - All tones high gives constant 1; none high gives constant 0.
- Simultaneous press/release on multiple keys: each channel is independent; no arbitration.

Decomposition:
- Package piano_pkg:
  - NOTE_HZ table (8 entries).
  - Function half_period(clk_hz, idx) returning round(clk_hz/(2*NOTE_HZ[idx])).
  - Popcount function.
- Sub-module tone_channel:
  - Synchroniser, debouncer and divider for one key.
  - Parameters CLK_HZ, DIV_W, DEBOUNCE_CYCLES, NOTE_IDX, OCT_OFFSET.
  - Instantiated NUM_KEYS times by generate.
- The top level holds the key_count and PDM logic.

Test Plan:
- Reset held, keys = 8'hFF toggling -> tone_out = 0, mix_out = 0, key_count = 0 throughout. Assert rst while tone_out[5] = 1 -> it drops to 0 with no clock edge.
- Press key 5 (A4), octave = 0, defaults -> debounced rise at 6 cycles. tone_out[5] first toggles 56818 cycles later, then period 113636 cycles. key_count = 1.
- Key 0 with 3-cycle raw pulses at 1/0/1 -> no debounced change, tone_out[0] stays 0. A 5-cycle stable press -> accepted.
- Key 5 held, octave switched 0 -> 1 mid half-period -> the current half-period completes at 56818 cycles, and subsequent half-periods are 28409 cycles.
- NUM_KEYS = 8, all keys forced on, then compare every cycle: popcount(tone_out) = 8 -> mix_out constantly 1; popcount = 4 -> mix_out alternates with 50% density (exactly 4 ones per 8 cycles).
- NUM_KEYS = 16, key 13 pressed -> F5 half-period = 71586 >> 1 = 35793 cycles. Release -> tone_out[13] = 0 one cycle after the debounced fall, and key_count returns to 0.
